// File: rtl/alu_defs_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bundle
// and a legality helper used by the datapath.
package alu_defs_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_NOT_A  = 4'd5,
    OP_SHL    = 4'd6,
    OP_SHR    = 4'd7,
    OP_INC_A  = 4'd8,
    OP_DEC_A  = 4'd9,
    OP_PASS_B = 4'd10,
    OP_CMP    = 4'd11
  } alu_op_e;

  // Encodings above this value are reserved and flagged as errors.
  localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic err;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '0;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder and one shared subtractor
// feed the arithmetic opcodes; logic/shift opcodes bypass them.
module alu_core
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;

  // INC/DEC reuse the ADD/SUB paths with a constant one as second operand.
  always_comb begin
    addend     = (op == OP_INC_A) ? ONE : b;
    subtrahend = (op == OP_DEC_A) ? ONE : b;
    sum        = {1'b0, a} + {1'b0, addend};
    diff       = {1'b0, a} - {1'b0, subtrahend};
    add_ovf    = (a[MSB] == addend[MSB]) && (sum[MSB] != a[MSB]);
    sub_ovf    = (a[MSB] != subtrahend[MSB]) && (diff[MSB] != a[MSB]);
  end

  always_comb begin
    result = '0;
    flags  = FLAGS_CLEAR;
    case (op)
      OP_ADD, OP_INC_A: begin
        result      = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = add_ovf;
      end
      OP_SUB, OP_DEC_A: begin
        result      = diff[WIDTH-1:0];
        flags.carry = diff[WIDTH];
        flags.ovf   = sub_ovf;
      end
      OP_CMP: begin
        result      = '0;
        flags.carry = diff[WIDTH];
        flags.ovf   = sub_ovf;
      end
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NOT_A:  result = ~a;
      OP_SHL:    result = a << b[2:0];
      OP_SHR:    result = a >> b[2:0];
      OP_PASS_B: result = b;
      default:   flags.err = 1'b1;
    endcase
    // CMP forces a zero result, so its zero flag reports equality instead.
    if (op_is_legal(op)) begin
      flags.zero = (op == OP_CMP) ? (a == b) : (result == '0);
    end
  end

endmodule

// File: rtl/alu_pipelined.sv
// Pipelined ALU: the datapath result is captured into stage 0 and then
// delayed through STAGES-1 further registers that stall as one unit.
module alu_pipelined
  import alu_defs_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             ovf_out,
  output logic             err_out,
  output logic [15:0]      op_count
);

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_in),
    .b      (b_in),
    .op     (op_in),
    .result (core_result),
    .flags  (core_flags)
  );

  logic             stg_valid  [STAGES];
  logic [WIDTH-1:0] stg_result [STAGES];
  alu_flags_t       stg_flags  [STAGES];
  logic             advance;

  // Handshake: a side transfers on a cycle where its valid and ready are both
  // high at the rising edge; valid must hold until it transfers. The whole
  // pipe moves only when the last stage is empty or being drained, so bubbles
  // never collapse and in_ready follows out_ready combinationally.
  assign out_valid = stg_valid[STAGES-1];
  assign in_ready  = out_ready || !out_valid;
  assign advance   = in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_valid[i]  <= 1'b0;
        stg_result[i] <= '0;
        stg_flags[i]  <= FLAGS_CLEAR;
      end
    end else if (advance) begin
      // Bubbles carry zeroed payload so idle outputs read as zero.
      stg_valid[0]  <= in_valid;
      stg_result[0] <= in_valid ? core_result : '0;
      stg_flags[0]  <= in_valid ? core_flags : FLAGS_CLEAR;
      for (int i = 1; i < STAGES; i++) begin
        stg_valid[i]  <= stg_valid[i-1];
        stg_result[i] <= stg_result[i-1];
        stg_flags[i]  <= stg_flags[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

  assign result_out = stg_result[STAGES-1];
  assign carry_out  = stg_flags[STAGES-1].carry;
  assign zero_out   = stg_flags[STAGES-1].zero;
  assign ovf_out    = stg_flags[STAGES-1].ovf;
  assign err_out    = stg_flags[STAGES-1].err;

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed bench for alu_pipelined (WIDTH=8, STAGES=2): reset, opcode
// results and flags, stall/ordering, illegal opcodes and mid-flight reset.
module tb_alu_pipelined;
  import alu_defs_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   op_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_out;
  logic         carry_out;
  logic         zero_out;
  logic         ovf_out;
  logic         err_out;
  logic [15:0]  op_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count = '0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t vecs[15];

  always #5 clock = ~clock;

  alu_pipelined #(.WIDTH(W), .STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_in      (op_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .carry_out  (carry_out),
    .zero_out   (zero_out),
    .ovf_out    (ovf_out),
    .err_out    (err_out),
    .op_count   (op_count)
  );

  // Present one operand set for exactly one rising edge, then withdraw it.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b1;
    op_in     = OP_ADD;
    a_in      = 8'h11;
    b_in      = 8'h22;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({out_valid, result_out, carry_out, zero_out, ovf_out, err_out} !== 13'd0)
        begin errors++; $display("FAIL reset_outputs cyc %0d: got v=%b r=%h f=%b%b%b%b expected all 0", i, out_valid, result_out, carry_out, zero_out, ovf_out, err_out); end
      checks++;
      if (op_count !== 16'd0)
        begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_carry;
    send(OP_ADD, 8'hFF, 8'h01);
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL add_latency_early: out_valid %b expected 0 one cycle after accept", out_valid); end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({out_valid, result_out} !== {1'b1, 8'h00})
      begin errors++; $display("FAIL add_ff_01_result: got v=%b r=%h expected v=1 r=00", out_valid, result_out); end
    checks++;
    if ({carry_out, zero_out, ovf_out, err_out} !== 4'b1100)
      begin errors++; $display("FAIL add_ff_01_flags: got czoe=%b%b%b%b expected 1100", carry_out, zero_out, ovf_out, err_out); end
    @(posedge clock);
    exp_count++;
    @(negedge clock);
    checks++;
    if ({out_valid, op_count} !== {1'b0, exp_count})
      begin errors++; $display("FAIL add_drain: got v=%b count=%0d expected v=0 count=%0d", out_valid, op_count, exp_count); end
  endtask

  task automatic test_opcodes;
    vecs[0]  = '{OP_SUB,    8'h80, 8'h01, 8'h7F, 4'b0010};
    vecs[1]  = '{OP_CMP,    8'h05, 8'h05, 8'h00, 4'b0100};
    vecs[2]  = '{OP_CMP,    8'h03, 8'h05, 8'h00, 4'b1000};
    vecs[3]  = '{OP_AND,    8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[4]  = '{OP_OR,     8'h0F, 8'hF0, 8'hFF, 4'b0000};
    vecs[5]  = '{OP_XOR,    8'h55, 8'h55, 8'h00, 4'b0100};
    vecs[6]  = '{OP_NOT_A,  8'hFF, 8'h00, 8'h00, 4'b0100};
    vecs[7]  = '{OP_SHL,    8'h81, 8'h0B, 8'h08, 4'b0000};
    vecs[8]  = '{OP_SHR,    8'h81, 8'h0A, 8'h20, 4'b0000};
    vecs[9]  = '{OP_INC_A,  8'h7F, 8'h00, 8'h80, 4'b0010};
    vecs[10] = '{OP_DEC_A,  8'h00, 8'h55, 8'hFF, 4'b1000};
    vecs[11] = '{OP_PASS_B, 8'h12, 8'h5A, 8'h5A, 4'b0000};
    vecs[12] = '{OP_ADD,    8'h7F, 8'h01, 8'h80, 4'b0010};
    vecs[13] = '{OP_SUB,    8'h05, 8'h07, 8'hFE, 4'b1000};
    vecs[14] = '{OP_INC_A,  8'hFF, 8'h00, 8'h00, 4'b1100};
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({out_valid, result_out} !== {1'b1, vecs[i].res})
        begin errors++; $display("FAIL op_%0d_result (op=%0d a=%h b=%h): got v=%b r=%h expected v=1 r=%h", i, vecs[i].op, vecs[i].a, vecs[i].b, out_valid, result_out, vecs[i].res); end
      checks++;
      if ({carry_out, zero_out, ovf_out, err_out} !== vecs[i].flg)
        begin errors++; $display("FAIL op_%0d_flags (op=%0d): got czoe=%b%b%b%b expected %b", i, vecs[i].op, carry_out, zero_out, ovf_out, err_out, vecs[i].flg); end
      @(posedge clock);
      exp_count++;
      @(negedge clock);
    end
    checks++;
    if (op_count !== exp_count)
      begin errors++; $display("FAIL op_count_after_opcodes: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    logic         was_stall;
    logic         fire_in;
    logic         fire_out;
    int           sent;
    int           delivered;
    int           cyc;
    was_stall = 1'b0;
    held      = '0;
    sent      = 0;
    delivered = 0;
    cyc       = 0;
    while ((sent < 3 || exp_q.size() != 0) && cyc < 40) begin
      out_ready = (cyc >= 3);
      if (sent < 3) begin
        in_valid = 1'b1;
        op_in    = OP_ADD;
        a_in     = W'(sent + 1);
        b_in     = W'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0)
          begin errors++; $display("FAIL b2b_in_ready_stall: got %b expected 0", in_ready); end
      end
      if (was_stall) begin
        checks++;
        if ({out_valid, result_out} !== {1'b1, held})
          begin errors++; $display("FAIL b2b_stall_stable: got v=%b r=%h expected v=1 r=%h", out_valid, result_out, held); end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_result: got r=%h expected none", result_out);
        end else if (result_out !== exp_q[0]) begin
          errors++; $display("FAIL b2b_order: got r=%h expected %h", result_out, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        delivered++;
        exp_count++;
      end
      was_stall = out_valid && !out_ready;
      held      = result_out;
      if (fire_in) begin
        exp_q.push_back(W'(2 * (sent + 1)));
        sent++;
      end
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 40)
      begin errors++; $display("FAIL b2b_timeout: got %0d outstanding expected 0", exp_q.size()); end
    checks++;
    if (delivered != 3)
      begin errors++; $display("FAIL b2b_delivered: got %0d expected 3", delivered); end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({out_valid, op_count} !== {1'b0, exp_count})
      begin errors++; $display("FAIL b2b_no_duplicate: got v=%b count=%0d expected v=0 count=%0d", out_valid, op_count, exp_count); end
  endtask

  task automatic test_illegal;
    send(4'hF, 8'h12, 8'h34);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({out_valid, result_out} !== {1'b1, 8'h00})
      begin errors++; $display("FAIL illegal_result: got v=%b r=%h expected v=1 r=00", out_valid, result_out); end
    checks++;
    if ({carry_out, zero_out, ovf_out, err_out} !== 4'b0001)
      begin errors++; $display("FAIL illegal_flags: got czoe=%b%b%b%b expected 0001", carry_out, zero_out, ovf_out, err_out); end
    @(posedge clock);
    exp_count++;
    @(negedge clock);
    send(OP_ADD, 8'h01, 8'h02);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({out_valid, result_out, carry_out, zero_out, ovf_out, err_out} !== {1'b1, 8'h03, 4'b0000})
      begin errors++; $display("FAIL after_illegal: got v=%b r=%h f=%b%b%b%b expected v=1 r=03 f=0000", out_valid, result_out, carry_out, zero_out, ovf_out, err_out); end
    @(posedge clock);
    exp_count++;
    @(negedge clock);
    checks++;
    if (op_count !== exp_count)
      begin errors++; $display("FAIL illegal_op_count: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    send(OP_ADD, 8'h10, 8'h20);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    exp_count = '0;
    seen      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0 || result_out === 8'h30) seen = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    checks++;
    if (seen)
      begin errors++; $display("FAIL midflight_result_leak: got a result after reset expected none"); end
    checks++;
    if (op_count !== exp_count)
      begin errors++; $display("FAIL midflight_op_count: got %0d expected %0d", op_count, exp_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_carry();
    test_opcodes();
    test_back_to_back();
    test_illegal();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
